// File: rtl/rand_pool_if.sv
// HART-side request/grant bundle of the entropy pool.
// The pool is the slave; each HART drives one req bit and watches its ack bit.
interface rand_pool_if #(
  parameter int NRAND = 1,
  parameter int WIDTH = 16
);
  logic [NRAND-1:0] req;
  logic [NRAND-1:0] ack;
  logic [WIDTH-1:0] data;
  logic             fail;

  modport master (output req, input ack, data, fail);
  modport slave  (input req, output ack, data, fail);
endinterface

// File: rtl/rand_pool.sv
// Multi-channel entropy pool.
// Health-checks raw sources, whitens them through an LFSR, packs words into a FIFO and grants them round-robin.
module rand_pool #(
  parameter int NRAND     = 1,
  parameter int NSRC      = 2,
  parameter int WIDTH     = 16,
  parameter int NBITS     = 5,
  parameter int DEPTH     = 4,
  parameter int RCT_LIMIT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_in,
  rand_pool_if.slave      rif,
  output logic [NSRC-1:0] chan_dead,
  output logic            rand_dead,
  output logic            overflow
);
  localparam int TW = $clog2(NBITS) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = (NRAND > 1) ? $clog2(NRAND) : 1;

  logic [NSRC-1:0]  r_src_reg;
  logic [NSRC-1:0]  r_prev_reg;
  logic [NSRC-1:0]  chan_dead_reg;
  logic [NSRC-1:0]  chan_dead_next;
  logic             rand_dead_reg;
  logic             rand_dead_next;
  logic [15:0]      lfsr_reg;
  logic             m_prev_reg;
  logic [TW-1:0]    tcnt_reg;
  logic [BW-1:0]    bcnt_reg;
  logic [WIDTH-2:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] word_reg;
  logic             word_vld_reg;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;

  logic [RW-1:0]    rr_ptr_reg;
  logic [NRAND-1:0] ack_reg;
  logic [WIDTH-1:0] data_reg;
  logic             fail_reg;

  logic             mix;
  logic             trans;
  logic             capture;
  logic [NRAND-1:0] elig;
  logic             gnt_found;
  logic [RW-1:0]    gnt_idx;
  logic             grant;
  logic             pop;
  logic             push;
  logic             push_ok;
  logic             full;
  logic             flush;

  // Repetition-count health test, one counter per channel.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_health
      logic [7:0] rep_reg;
      logic [7:0] rep_next;

      always_comb begin
        if (r_src_reg[gi] != r_prev_reg[gi])
          rep_next = 8'd0;
        else if (rep_reg == 8'hFF)
          rep_next = rep_reg;
        else
          rep_next = rep_reg + 8'd1;
        chan_dead_next[gi] = chan_dead_reg[gi] | (rep_next >= 8'(RCT_LIMIT));
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rep_reg           <= 8'd0;
          chan_dead_reg[gi] <= 1'b0;
        end else begin
          rep_reg           <= rep_next;
          chan_dead_reg[gi] <= chan_dead_next[gi];
        end
      end
    end
  endgenerate

  assign rand_dead_next = &chan_dead_next;
  assign mix            = ^(r_src_reg & ~chan_dead_reg);
  assign trans          = (mix != m_prev_reg);
  assign capture        = trans && (tcnt_reg == TW'(NBITS - 1)) && !rand_dead_reg;
  assign acc_next       = {acc_reg, lfsr_reg[0]};

  // Sampling, whitening and bit packing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_reg     <= '0;
      r_prev_reg    <= '0;
      rand_dead_reg <= 1'b0;
      lfsr_reg      <= 16'h0001;
      m_prev_reg    <= 1'b0;
      tcnt_reg      <= '0;
      bcnt_reg      <= '0;
      acc_reg       <= '0;
      word_reg      <= '0;
      word_vld_reg  <= 1'b0;
    end else begin
      r_src_reg     <= src_in;
      r_prev_reg    <= r_src_reg;
      rand_dead_reg <= rand_dead_next;
      lfsr_reg      <= {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3] ^ mix};
      m_prev_reg    <= mix;
      word_vld_reg  <= 1'b0;
      if (trans)
        tcnt_reg <= (tcnt_reg == TW'(NBITS - 1)) ? '0 : tcnt_reg + TW'(1);
      if (capture) begin
        acc_reg <= acc_next[WIDTH-2:0];
        if (bcnt_reg == BW'(WIDTH - 1)) begin
          bcnt_reg     <= '0;
          word_reg     <= acc_next;
          word_vld_reg <= 1'b1;
        end else begin
          bcnt_reg <= bcnt_reg + BW'(1);
        end
      end
    end
  end

  // A HART acked this cycle still shows req high, so it sits out one decision.
  assign elig = rif.req & ~ack_reg;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NRAND; k++) begin
      if (!gnt_found && elig[(int'(rr_ptr_reg) + k) % NRAND]) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'((int'(rr_ptr_reg) + k) % NRAND);
      end
    end
  end

  assign grant   = gnt_found && ((count_reg != '0) || rand_dead_reg);
  assign pop     = grant && !rand_dead_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign push    = word_vld_reg && !rand_dead_reg;
  assign push_ok = push && (!full || pop);
  assign flush   = rand_dead_next && !rand_dead_reg;

  // FIFO control; losing all entropy empties the buffer for good.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (push && full && !pop)
        overflow_reg <= 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok)
      mem[wr_ptr_reg] <= word_reg;
  end

  always_ff @(posedge clk) begin
    if (reset)
      data_reg <= '0;
    else if (pop)
      data_reg <= mem[rd_ptr_reg];
    else
      data_reg <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg    <= '0;
      fail_reg   <= 1'b0;
      rr_ptr_reg <= '0;
    end else begin
      ack_reg  <= grant ? (NRAND'(1) << gnt_idx) : '0;
      fail_reg <= grant && rand_dead_reg;
      if (grant)
        rr_ptr_reg <= (gnt_idx == RW'(NRAND - 1)) ? '0 : gnt_idx + RW'(1);
    end
  end

  assign rif.ack   = ack_reg;
  assign rif.data  = data_reg;
  assign rif.fail  = fail_reg;
  assign chan_dead = chan_dead_reg;
  assign rand_dead = rand_dead_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_rand_pool.sv
// Self-checking bench for rand_pool: a cycle reference model predicts words into a scoreboard queue,
// and every ack pops and compares against it.
module tb_rand_pool;
  localparam int NRAND = 3;
  localparam int NSRC  = 2;
  localparam int WIDTH = 8;
  localparam int NBITS = 3;
  localparam int DEPTH = 4;
  localparam int RCT   = 20;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_RAND  = 1;
  localparam int MODE_CH1_0 = 2;
  localparam int MODE_STUCK = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] src_in = '0;
  logic [NSRC-1:0] chan_dead;
  logic            rand_dead;
  logic            overflow;

  rand_pool_if #(.NRAND(NRAND), .WIDTH(WIDTH)) rif();

  rand_pool #(
    .NRAND(NRAND), .NSRC(NSRC), .WIDTH(WIDTH),
    .NBITS(NBITS), .DEPTH(DEPTH), .RCT_LIMIT(RCT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_in(src_in),
    .rif(rif.slave),
    .chan_dead(chan_dead),
    .rand_dead(rand_dead),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_total = 0;
  int mode = MODE_IDLE;
  logic tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source pattern generator; IDLE toggles both channels together so mix stays constant.
  always @(negedge clk) begin
    tog = ~tog;
    case (mode)
      MODE_IDLE:  src_in = {tog, tog};
      MODE_RAND:  src_in = NSRC'($urandom);
      MODE_CH1_0: src_in = {1'b0, tog};
      default:    src_in = '0;
    endcase
  end

  // Reference model state
  logic [NSRC-1:0]  m_r_src, m_r_prev, m_dead;
  int               m_rep [NSRC];
  logic             m_rdead, m_rdead_prev, m_mprev, m_wpend, m_ovf;
  logic [15:0]      m_lfsr;
  int               m_tcnt, m_bcnt;
  logic [WIDTH-1:0] m_acc, m_word;
  logic [WIDTH-1:0] exp_q[$];
  int               exp_hart_q[$];

  always @(posedge clk) begin : model
    logic            m;
    logic            wp;
    logic [NSRC-1:0] dn;
    logic [WIDTH-1:0] an;
    int              rn;
    if (reset) begin
      m_r_src = '0; m_r_prev = '0; m_dead = '0;
      for (int i = 0; i < NSRC; i++) m_rep[i] = 0;
      m_rdead = 1'b0; m_rdead_prev = 1'b0; m_mprev = 1'b0; m_wpend = 1'b0; m_ovf = 1'b0;
      m_lfsr = 16'h0001; m_tcnt = 0; m_bcnt = 0; m_acc = '0; m_word = '0;
      exp_q.delete();
    end else begin
      m = ^(m_r_src & ~m_dead);
      m_rdead_prev = m_rdead;
      dn = m_dead;
      for (int i = 0; i < NSRC; i++) begin
        rn = (m_r_src[i] != m_r_prev[i]) ? 0 : ((m_rep[i] >= 255) ? 255 : m_rep[i] + 1);
        m_rep[i] = rn;
        if (rn >= RCT) dn[i] = 1'b1;
      end
      if ((&dn) && !m_rdead)
        exp_q.delete();
      else if (m_wpend && !m_rdead) begin
        if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(m_word);
      end
      wp = 1'b0;
      if (m != m_mprev) begin
        if (m_tcnt == NBITS - 1) begin
          m_tcnt = 0;
          if (!m_rdead) begin
            an = {m_acc[WIDTH-2:0], m_lfsr[0]};
            m_acc = an;
            if (m_bcnt == WIDTH - 1) begin
              m_bcnt = 0; m_word = an; wp = 1'b1;
            end else begin
              m_bcnt++;
            end
          end
        end else begin
          m_tcnt++;
        end
      end
      m_wpend = wp;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3] ^ m};
      m_mprev = m;
      m_dead = dn;
      m_rdead = &dn;
      m_r_prev = m_r_src;
      m_r_src = src_in;
    end
  end

  // Output monitor: one line per grant, scoreboard pop on each ack.
  always @(negedge clk) begin : monitor
    int h;
    if (!reset) begin
      check("chan_dead", 32'(chan_dead), 32'(m_dead));
      check("rand_dead", 32'(rand_dead), 32'(m_rdead));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("ack_onehot0", 32'($onehot0(rif.ack)), 32'd1);
      if (rif.ack != '0) begin
        ack_total++;
        h = 0;
        for (int i = 0; i < NRAND; i++) if (rif.ack[i]) h = i;
        $display("ack hart=%0d data=%h fail=%b", h, rif.data, rif.fail);
        if (exp_hart_q.size() > 0) check("rr_order", 32'(h), 32'(exp_hart_q.pop_front()));
        check("fail", 32'(rif.fail), 32'(m_rdead_prev));
        if (m_rdead_prev)
          check("fail_data", 32'(rif.data), 32'd0);
        else if (exp_q.size() == 0)
          check("ack_while_empty", 32'(rif.ack), 32'd0);
        else
          check("word", 32'(rif.data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_acks(input string tag, input int n, input int budget);
    int target;
    int cyc;
    target = ack_total + n;
    cyc = 0;
    while (ack_total < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_acks"}, 32'(ack_total >= target), 32'd1);
  endtask

  initial begin : main
    int base;
    int cyc;
    rif.req = '0;
    reset = 1'b1;
    mode = MODE_IDLE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(rif.ack), 32'd0);
    check("rst_data", 32'(rif.data), 32'd0);
    check("rst_fail", 32'(rif.fail), 32'd0);
    check("rst_chan_dead", 32'(chan_dead), 32'd0);
    check("rst_rand_dead", 32'(rand_dead), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_reg), 32'h0001);
    reset = 1'b0;

    // Words delivered to a single requester.
    mode = MODE_RAND;
    rif.req = 3'b001;
    wait_acks("single", 3, 3000);
    @(negedge clk);
    rif.req = '0;

    // Reset in the middle of filling the FIFO.
    cyc = 0;
    while (exp_q.size() < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("fill2", 32'(exp_q.size() >= 2), 32'd1);
    reset = 1'b1;
    mode = MODE_IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_ack", 32'(rif.ack), 32'd0);
    reset = 1'b0;
    base = ack_total;
    rif.req = 3'b001;
    repeat (12) @(negedge clk);
    check("no_ack_empty", 32'(ack_total - base), 32'd0);
    rif.req = '0;

    // Fill past DEPTH with nobody requesting.
    mode = MODE_RAND;
    cyc = 0;
    while (!m_ovf && cyc < 4000) begin @(negedge clk); cyc++; end
    mode = MODE_IDLE;
    repeat (2) @(negedge clk);
    check("overflow_set", 32'(overflow), 32'd1);

    // Round-robin drain of the full FIFO.
    exp_hart_q.push_back(0);
    exp_hart_q.push_back(1);
    exp_hart_q.push_back(2);
    exp_hart_q.push_back(0);
    base = ack_total;
    rif.req = 3'b111;
    repeat (10) @(negedge clk);
    check("rr_acks", 32'(ack_total - base), 32'd4);
    check("rr_pending", 32'(exp_hart_q.size()), 32'd0);
    rif.req = '0;

    // Channel 1 stuck: words continue from channel 0.
    mode = MODE_CH1_0;
    rif.req = 3'b001;
    wait_acks("ch0_only", 3, 3000);
    @(negedge clk);
    rif.req = '0;
    check("ch1_dead", 32'(chan_dead), 32'h2);
    check("ch1_rand_dead", 32'(rand_dead), 32'd0);

    // Every channel stuck: grants answer with fail.
    mode = MODE_STUCK;
    cyc = 0;
    while (!rand_dead && cyc < 200) begin @(negedge clk); cyc++; end
    check("all_rand_dead", 32'(rand_dead), 32'd1);
    check("all_chan_dead", 32'(chan_dead), 32'h3);
    rif.req = 3'b001;
    wait_acks("dead", 2, 20);
    @(negedge clk);
    rif.req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
